// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-requester UART transmitter. Round-robin arbitration picks
// one byte source and frames its byte as start/data/stop on a shared TX line.
// Each bit lasts one BAUD tick period. All outputs come straight from registers.
module uart_tx_sched #(
    parameter int pDataBits = 8,
    parameter int pStopBits = 1
) (
    input  logic                 CLOCK,
    input  logic                 RST,
    input  logic                 BAUD,
    input  logic                 REQ0,
    input  logic [pDataBits-1:0] DATA0,
    output logic                 ACK0,
    input  logic                 REQ1,
    input  logic [pDataBits-1:0] DATA1,
    output logic                 ACK1,
    output logic                 TX,
    output logic                 BUSY,
    output logic                 GRANT
);

    localparam int CW = (pDataBits > 1) ? $clog2(pDataBits) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(pDataBits - 1);
    localparam bit TWO_STOP = (pStopBits == 2);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state, state_next;
    logic                   tx_r, tx_next;
    logic                   busy_r, busy_next;
    logic                   ack0_r, ack0_next;
    logic                   ack1_r, ack1_next;
    logic                   grant_r, grant_next;
    logic                   last_served, last_next;
    logic [pDataBits-1:0]   shreg, shreg_next;
    logic [CW-1:0]          bit_cnt, bit_cnt_next;
    logic                   stop_cnt, stop_cnt_next;
    logic                   pick;

    // Round-robin choice: a lone requester wins outright; on a tie the
    // requester that was not served last time wins.
    always_comb begin
        pick = REQ1;
        if (REQ0 && REQ1) begin
            pick = ~last_served;
        end
    end

    // Next-state logic: grant in IDLE, then walk start/data/stop bits,
    // advancing only on BAUD ticks so every bit is one tick period long.
    always_comb begin
        state_next    = state;
        tx_next       = tx_r;
        ack0_next     = 1'b0;
        ack1_next     = 1'b0;
        grant_next    = grant_r;
        last_next     = last_served;
        shreg_next    = shreg;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;

        unique case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (REQ0 || REQ1) begin
                    shreg_next = pick ? DATA1 : DATA0;
                    ack0_next  = ~pick;
                    ack1_next  = pick;
                    grant_next = pick;
                    last_next  = pick;
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (BAUD) begin
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (BAUD) begin
                    tx_next      = shreg[0];
                    shreg_next   = shreg >> 1;
                    bit_cnt_next = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (BAUD) begin
                    if (bit_cnt < LAST_BIT) begin
                        bit_cnt_next = bit_cnt + 1'b1;
                        tx_next      = shreg[0];
                        shreg_next   = shreg >> 1;
                    end else begin
                        tx_next       = 1'b1;
                        stop_cnt_next = 1'b0;
                        state_next    = STOP;
                    end
                end
            end
            STOP: begin
                if (BAUD) begin
                    if (TWO_STOP && (stop_cnt == 1'b0)) begin
                        stop_cnt_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // State and output registers; reset abandons any frame in flight and
    // hands the first tie to requester 0.
    always_ff @(posedge CLOCK) begin
        if (RST) begin
            state       <= IDLE;
            tx_r        <= 1'b1;
            busy_r      <= 1'b0;
            ack0_r      <= 1'b0;
            ack1_r      <= 1'b0;
            grant_r     <= 1'b0;
            last_served <= 1'b1;
            shreg       <= '0;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
        end else begin
            state       <= state_next;
            tx_r        <= tx_next;
            busy_r      <= busy_next;
            ack0_r      <= ack0_next;
            ack1_r      <= ack1_next;
            grant_r     <= grant_next;
            last_served <= last_next;
            shreg       <= shreg_next;
            bit_cnt     <= bit_cnt_next;
            stop_cnt    <= stop_cnt_next;
        end
    end

    assign TX    = tx_r;
    assign BUSY  = busy_r;
    assign ACK0  = ack0_r;
    assign ACK1  = ack1_r;
    assign GRANT = grant_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench for uart_tx_sched. Two lanes run in
// parallel, one with 8 data/1 stop bit and one with 7 data/2 stop bits.
module tb_uart_tx_sched;

    logic CLOCK = 1'b0;
    int   errors = 0;
    int   checks = 0;
    bit   done [2];

    // Free-running system clock
    always #5 CLOCK = ~CLOCK;

    task automatic checkOutput(input int lane, input string name,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL lane%0d %s: got 0x%0h, expected 0x%0h", lane, name, actual, expected);
        end
    endtask

    task automatic reportFail(input int lane, input string name);
        checks++;
        errors++;
        $display("[TB] FAIL lane%0d %s: got no matching event, expected one", lane, name);
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int D     = (g == 0) ? 8 : 7;
        localparam int S     = (g == 0) ? 1 : 2;
        localparam int BOUND = 600;

        logic       rst = 1'b1;
        logic       baud = 1'b0;
        logic       req [2];
        logic [8:0] data [2];
        logic       ack [2];
        logic       tx, busy, grant;
        int         bcnt = g;

        int  ack_idx_q[$];
        int  ack_cyc_q[$];
        int  frame_q[$];
        int  start_q[$];
        int  cyc = 0;
        bit  free = 1'b1;
        int  last = 1;
        int  rem = 0;
        int  win = 0;
        bit  rst_edge = 1'b0;
        bit  baud_edge = 1'b0;
        bit  started = 1'b0;
        int  ai, ac;
        bit  in_frame = 1'b0;
        int  tick = 0;
        int  value = 0;
        logic prev_tx = 1'b1;

        uart_tx_sched #(.pDataBits(D), .pStopBits(S)) dut (
            .CLOCK (CLOCK),
            .RST   (rst),
            .BAUD  (baud),
            .REQ0  (req[0]),
            .DATA0 (data[0][D-1:0]),
            .ACK0  (ack[0]),
            .REQ1  (req[1]),
            .DATA1 (data[1][D-1:0]),
            .ACK1  (ack[1]),
            .TX    (tx),
            .BUSY  (busy),
            .GRANT (grant)
        );

        // BAUD tick every 4 clocks, changed on the falling edge
        always @(negedge CLOCK) begin
            bcnt = (bcnt + 1) % 4;
            baud = (bcnt == 0);
        end

        // Reference model: a frame occupies the line for 2+D+S ticks after
        // its grant; a free line grants by round-robin on any request.
        always @(posedge CLOCK) begin
            cyc++;
            rst_edge  = rst;
            baud_edge = baud;
            if (rst) begin
                started = 1'b1;
                free = 1'b1;
                last = 1;
                rem  = 0;
                ack_idx_q.delete();
                ack_cyc_q.delete();
                frame_q.delete();
                start_q.delete();
            end else if (!free) begin
                if (baud) begin
                    rem--;
                    if (rem == 1 + D + S) start_q.push_back(cyc);
                    if (rem == 0) free = 1'b1;
                end
            end else if (req[0] || req[1]) begin
                win  = (req[0] && req[1]) ? 1 - last : (req[1] ? 1 : 0);
                last = win;
                free = 1'b0;
                rem  = 2 + D + S;
                ack_idx_q.push_back(win);
                ack_cyc_q.push_back(cyc);
                frame_q.push_back(int'(data[win]) & ((1 << D) - 1));
            end
        end

        // Handshake monitor: reset values, ACK order, timing and GRANT
        always @(negedge CLOCK) begin
            if (started) begin
                if (rst_edge) begin
                    checkOutput(g, "reset_ack0", 32'(ack[0]), 0);
                    checkOutput(g, "reset_ack1", 32'(ack[1]), 0);
                    checkOutput(g, "reset_tx", 32'(tx), 1);
                    checkOutput(g, "reset_busy", 32'(busy), 0);
                    checkOutput(g, "reset_grant", 32'(grant), 0);
                end else if (ack[0] === 1'b1 && ack[1] === 1'b1) begin
                    reportFail(g, "ack_overlap");
                end else if (ack[0] === 1'b1 || ack[1] === 1'b1) begin
                    if (ack_idx_q.size() == 0) begin
                        reportFail(g, "unexpected_ack");
                    end else begin
                        ai = ack_idx_q.pop_front();
                        ac = ack_cyc_q.pop_front();
                        checkOutput(g, "ack_index", (ack[1] === 1'b1) ? 1 : 0, ai);
                        checkOutput(g, "ack_cycle", cyc, ac);
                        checkOutput(g, "grant", 32'(grant), ai);
                        checkOutput(g, "busy_after_grant", 32'(busy), 1);
                    end
                end else if (ack_cyc_q.size() != 0 && ack_cyc_q[0] <= cyc) begin
                    reportFail(g, "missing_ack");
                    ai = ack_idx_q.pop_front();
                    ac = ack_cyc_q.pop_front();
                end
            end
        end

        // Line monitor: decodes frames on TX tick by tick and scores them
        always @(negedge CLOCK) begin
            if (started) begin
                if (rst_edge) begin
                    in_frame = 1'b0;
                end else begin
                    if (tx !== prev_tx && !baud_edge) begin
                        checkOutput(g, "tx_between_ticks", 32'(tx), 32'(prev_tx));
                    end
                    if (!in_frame) begin
                        if (prev_tx === 1'b1 && tx === 1'b0) begin
                            in_frame = 1'b1;
                            tick  = 0;
                            value = 0;
                            if (start_q.size() == 0) reportFail(g, "unexpected_start");
                            else checkOutput(g, "start_cycle", cyc, start_q.pop_front());
                            checkOutput(g, "busy_start", 32'(busy), 1);
                        end
                    end else if (baud_edge) begin
                        tick++;
                        if (tick <= D) begin
                            value = value | (((tx === 1'b1) ? 1 : 0) << (tick - 1));
                            checkOutput(g, "busy_data", 32'(busy), 1);
                        end else if (tick <= D + S) begin
                            checkOutput(g, "stop_bit", 32'(tx), 1);
                            checkOutput(g, "busy_stop", 32'(busy), 1);
                        end else begin
                            in_frame = 1'b0;
                            checkOutput(g, "idle_tx", 32'(tx), 1);
                            checkOutput(g, "busy_after_frame", 32'(busy), 0);
                            if (frame_q.size() == 0) reportFail(g, "unexpected_frame");
                            else checkOutput(g, "frame_data", value, frame_q.pop_front());
                        end
                    end
                end
                prev_tx = tx;
            end
        end

        task automatic applyStimulus(input int idx, input logic [8:0] val,
                                     input bit keep, input int maxWait);
            int  n = 0;
            bit  acked = 1'b0;
            data[idx] = val;
            req[idx]  = 1'b1;
            while (!acked && n < ((maxWait > 0) ? maxWait : BOUND)) begin
                @(posedge CLOCK);
                #1;
                n++;
                acked = (ack[idx] === 1'b1);
            end
            if (!acked) begin
                req[idx] = 1'b0;
                if (maxWait == 0) reportFail(g, "ack_timeout");
            end else if (!keep) begin
                req[idx] = 1'b0;
            end
        endtask

        task automatic waitIdle();
            int n = 0;
            while (!(free && frame_q.size() == 0 && ack_idx_q.size() == 0 && !in_frame) && n < 2000) begin
                @(posedge CLOCK);
                #1;
                n++;
            end
            if (n >= 2000) reportFail(g, "idle_timeout");
        endtask

        task automatic doReset();
            rst = 1'b1;
            @(posedge CLOCK);
            #1;
            rst = 1'b0;
        endtask

        task automatic randomRequester(input int idx);
            for (int i = 0; i < 25; i++) begin
                int w = $urandom_range(10, 0);
                repeat (w) begin
                    @(posedge CLOCK);
                    #1;
                end
                if ($urandom_range(4, 0) == 0)
                    applyStimulus(idx, 9'($urandom), 1'b0, $urandom_range(6, 1));
                else
                    applyStimulus(idx, 9'($urandom), (i < 24) && ($urandom_range(1, 0) == 1), 0);
            end
        endtask

        // Directed scenarios followed by randomized contention
        initial begin
            int n;
            int k;
            req[0] = 1'b0;
            req[1] = 1'b0;
            data[0] = '0;
            data[1] = '0;
            repeat (3) @(posedge CLOCK);
            #1;
            rst = 1'b0;

            applyStimulus(0, 9'h0A5, 1'b0, 0);
            waitIdle();

            doReset();
            fork
                begin
                    applyStimulus(0, 9'h055, 1'b1, 0);
                    applyStimulus(0, 9'h033, 1'b0, 0);
                end
                applyStimulus(1, 9'h00F, 1'b0, 0);
            join
            waitIdle();

            applyStimulus(1, 9'h000, 1'b1, 0);
            applyStimulus(1, 9'h0FF, 1'b1, 0);
            applyStimulus(1, 9'h081, 1'b0, 0);
            waitIdle();

            applyStimulus(0, 9'h07F, 1'b0, 0);
            waitIdle();

            k = 0;
            while (bcnt != 3 && k < 8) begin
                @(posedge CLOCK);
                #1;
                k++;
            end
            applyStimulus(1, 9'h05A, 1'b0, 0);
            waitIdle();

            applyStimulus(0, 9'h03C, 1'b0, 0);
            n = 0;
            k = 0;
            while (n < 5 && k < BOUND) begin
                @(posedge CLOCK);
                k++;
                if (baud) n++;
            end
            #1;
            @(posedge CLOCK);
            #1;
            doReset();
            applyStimulus(1, 9'h096, 1'b0, 0);
            waitIdle();

            applyStimulus(1, 9'h03A, 1'b0, 0);
            repeat (6) @(posedge CLOCK);
            #1;
            data[0] = 9'h011;
            req[0]  = 1'b1;
            @(posedge CLOCK);
            #1;
            req[0]  = 1'b0;
            waitIdle();

            fork
                randomRequester(0);
                randomRequester(1);
            join
            waitIdle();
            checkOutput(g, "leftover_frames", frame_q.size(), 0);
            checkOutput(g, "leftover_acks", ack_idx_q.size(), 0);
            done[g] = 1'b1;
        end
    end

    // Wait for both lanes, then summarize
    initial begin
        int n = 0;
        while (!(done[0] && done[1]) && n < 60000) begin
            @(posedge CLOCK);
            n++;
        end
        if (!(done[0] && done[1])) reportFail(-1, "global_timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Two-requester UART transmit scheduler. Arbitrates two byte sources round-robin onto one serial TX line. Frames each byte as start/data/stop, paced by the single-cycle BAUD tick from the baud generator. Sits between the baud generator and the TX pin; owns the shared serializer so the requesters never talk to the line directly.

## Interface
Parameters:
- pDataBits, 8, data bits per frame, LSB first (legal 5..9)
- pStopBits, 1, stop bits per frame (legal 1 or 2)

Ports:
- CLOCK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- BAUD  in  1  one-CLOCK-wide bit-period tick from the baud generator
- REQ0  in  1  requester 0 has a byte; held high until ACK0
- DATA0  in  pDataBits  requester 0 byte; stable while REQ0 high
- ACK0  out  1  one-cycle pulse: DATA0 latched
- REQ1, DATA1, ACK1  same as the requester 0 ports, for requester 1
- TX  out  1  serial line, idle high
- BUSY  out  1  high whenever state is not IDLE
- GRANT  out  1  index of requester owning the current/last frame

## Operation
- All outputs registered. Reset values: TX=1, BUSY=0, ACK0=ACK1=0, GRANT=0. Internal last-served pointer resets to 1, so requester 0 wins the first tie.
- States: IDLE, ARMED, START, DATA, STOP.
- IDLE: on an edge with REQ0|REQ1 high:
  - Grant: the only requester asserting; if both, the one not equal to last-served.
  - Latch its DATA into the shift register.
  - Pulse its ACK, set GRANT and last-served to its index.
  - Go to ARMED.
  - Without a request, stay IDLE with TX=1. BAUD is ignored in IDLE.
- ARMED: wait for BAUD. On a tick: TX<=0, go to START.
- START: on BAUD: TX<=data bit 0, bit counter<=0, go to DATA.
- DATA: on BAUD:
  - If counter < pDataBits-1: increment the counter and drive the next bit on TX.
  - Else: TX<=1, stop counter<=0, go to STOP.
- STOP: on BAUD:
  - If stop counter < pStopBits-1: increment it.
  - Else: go to IDLE. TX stays 1.
- Between ticks, every state holds TX and its counters.
- Counters are ceil(log2(pDataBits)) and 1 bit wide. No wrap occurs within legal parameters.
- A requester may drop REQ before being granted. It is then never ACKed, and no frame is produced for it.
- REQ is not sampled outside IDLE. Pending requests wait.
- RST in any state, including mid-frame, takes effect at that edge: reset values apply, state goes to IDLE, the latched byte is discarded, and no ACK is issued.

## Timing
- Grant latency: REQ high at edge k in IDLE, so ACK is high for exactly the cycle after edge k. State is ARMED from the same edge.
- BAUD coincident with the grant edge does not start the frame. The frame starts at the first tick sampled in ARMED.
- Each bit, start bit included, is held exactly one BAUD period, from the tick that drives it to the next tick.
- Frame length: 1+pDataBits+pStopBits tick periods, measured from the tick entering START to the tick returning to IDLE.
- Back-to-back: the return-to-IDLE tick leaves TX=1. The earliest possible grant is the next edge. The next start bit begins at the following tick, so the last stop bit is never shortened.
- Both requesters held continuously: grants alternate 0,1,0,1,...
- BUSY rises the cycle after the grant edge and falls the cycle after the final stop tick.

## Test plan
- Single frame: BAUD every 4 clocks; REQ0 with DATA0=0xA5. Required: one ACK0 pulse; TX = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; BUSY low afterwards; GRANT=0.
- Contention after reset: REQ0 with 0x55 and REQ1 with 0x0F asserted on the same edge, then both re-requesting. Required: order 0x55, 0x0F, next requester 0; ACKs never overlap.
- Back-to-back: REQ1 held with three bytes (0x00, 0xFF, 0x81). Required: each stop bit exactly 4 clocks high; no idle tick period between frames beyond grant/ARMED alignment; data matches LSB-first.
- Reset mid-frame: assert RST during DATA bit 3 of 0x3C. Required: TX=1, BUSY=0, GRANT=0 the cycle after; no partial resumption; next REQ1-only request still transmits.
- pStopBits=2, pDataBits=7: send 0x7F. Required: 7 data bits then TX high for 8 clocks before IDLE.
- Edge cases: BAUD coincident with the grant edge. Required: start bit begins at the next tick. REQ0 pulsed for one cycle while BUSY, then dropped. Required: no ACK0 and no frame.
